// File: rtl/riscv_fetch_queue.sv
// riscv_fetch_queue: PC, ready/valid imem request/response and DEPTH-entry prefetch queue with redirect flush.
// Optional FETCH_MISALIGN_CHK_EN: flag misaligned redirects and stall fetch until an aligned redirect.
module riscv_fetch_queue #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = 32'h0040_0000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  output logic                         imem_req_valid,
  output logic [ADDR_WIDTH-1:0]        imem_req_addr,
  input  logic                         imem_req_ready,
  input  logic                         imem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]        imem_rsp_data,
  input  logic                         redirect_valid,
  input  logic [ADDR_WIDTH-1:0]        redirect_pc,
  output logic                         instr_valid,
  output logic [DATA_WIDTH-1:0]        instr_data,
  output logic [ADDR_WIDTH-1:0]        instr_pc,
  input  logic                         instr_ready,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         misalign_err
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);
  typedef enum logic {RUN, FLUSH} state_t;
  state_t state_q, state_d;
  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d, rsp_pc_q, rsp_pc_d, redir_pc;
  logic [CW-1:0] count_q, count_d, out_q, out_d, discard_q, discard_d;
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic misalign_q, misalign_d;
  logic req_fire, rsp_fire, push, pop_eff;
  logic [ADDR_WIDTH-1:0] pc_mem [DEPTH];
  logic [DATA_WIDTH-1:0] data_mem [DEPTH];
`ifdef FETCH_MISALIGN_CHK_EN
  assign redir_pc = redirect_pc;
  assign misalign_d = redirect_valid ? |redirect_pc[1:0] : misalign_q;
`else
  logic unused_low_bits;
  assign unused_low_bits = ^redirect_pc[1:0];
  assign redir_pc = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
  assign misalign_d = 1'b0;
`endif
  // queue space is reserved at issue time, so responses can never overflow it
  assign imem_req_valid = !rst && en && state_q == RUN && !misalign_q &&
                          ({1'b0, count_q} + {1'b0, out_q}) < (CW+1)'(DEPTH);
  assign imem_req_addr = fetch_pc_q;
  assign req_fire = imem_req_valid & imem_req_ready;
  assign rsp_fire = imem_rsp_valid;
  assign push = rsp_fire && state_q == RUN && !redirect_valid;
  assign pop_eff = instr_valid && instr_ready && !redirect_valid;
  assign instr_valid = count_q != '0;
  assign instr_data = data_mem[head_q];
  assign instr_pc = pc_mem[head_q];
  assign count = count_q;
  assign misalign_err = misalign_q;
  always_comb begin
    out_d = out_q + CW'(req_fire) - CW'(rsp_fire);
    count_d = redirect_valid ? '0 : count_q + CW'(push) - CW'(pop_eff);
    head_d = redirect_valid ? '0 : head_q + PW'(pop_eff);
    tail_d = redirect_valid ? '0 : tail_q + PW'(push);
    fetch_pc_d = redirect_valid ? redir_pc : req_fire ? fetch_pc_q + 4 : fetch_pc_q;
    rsp_pc_d = redirect_valid ? redir_pc : push ? rsp_pc_q + 4 : rsp_pc_q;
    // everything still in flight at a redirect, including this cycle's accept, is stale
    discard_d = redirect_valid ? out_d : (state_q == FLUSH && rsp_fire) ? discard_q - 1'b1 : discard_q;
    state_d = redirect_valid ? (out_d != '0 ? FLUSH : RUN) :
              (state_q == FLUSH && discard_d == '0) ? RUN : state_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      fetch_pc_q <= RESET_PC;
      rsp_pc_q <= RESET_PC;
      count_q <= '0;
      out_q <= '0;
      discard_q <= '0;
      head_q <= '0;
      tail_q <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q <= rsp_pc_d;
      count_q <= count_d;
      out_q <= out_d;
      discard_q <= discard_d;
      head_q <= head_d;
      tail_q <= tail_d;
      misalign_q <= misalign_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[tail_q] <= rsp_pc_q;
      data_mem[tail_q] <= imem_rsp_data;
    end
  end
endmodule

// File: tb/tb_riscv_fetch_queue.sv
// tb_riscv_fetch_queue: directed test-plan sequences plus randomized traffic against a queue-based fetch model.
module tb_riscv_fetch_queue;
  localparam int DEPTH = 4;
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [31:0] RPC = 32'h0040_0000;
  logic clk = 1'b0, rst, en, imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic redirect_valid, instr_valid, instr_ready, misalign_err;
  logic [31:0] imem_req_addr, imem_rsp_data, redirect_pc, instr_data, instr_pc;
  logic [CW-1:0] count;
  always #5 clk = ~clk;
  riscv_fetch_queue #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst), .en(en),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_data(instr_data), .instr_pc(instr_pc), .instr_ready(instr_ready),
    .count(count), .misalign_err(misalign_err)
  );
  typedef struct {logic [31:0] addr; int due; bit stale;} mreq_t;
  mreq_t mq[$];
  logic [31:0] eq_pc[$];
  logic [31:0] exp_fetch, s_req_addr, s_ipc;
  bit exp_mis, s_req_valid, s_req_fire, s_rsp_fire, s_ivalid;
  int cyc = 0, n_req = 0, mem_lat = 1, rsp_pct = 100, n_tests = 0, n_fail = 0;
  function automatic logic [31:0] mem_word(logic [31:0] a);
    return ~a ^ {a[15:0], a[31:16]};
  endfunction
  task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    int stale_n = 0;
    bit rf, pf;
    imem_rsp_valid = mq.size() != 0 && mq[0].due <= cyc && $urandom_range(99) < rsp_pct;
    imem_rsp_data = mq.size() != 0 ? mem_word(mq[0].addr) : 32'h0;
    #1;
    foreach (mq[i]) if (mq[i].stale) stale_n++;
    check_eq("req_valid", imem_req_valid, en && !exp_mis && stale_n == 0 && eq_pc.size() + mq.size() < DEPTH);
    if (imem_req_valid) check_eq("req_addr", imem_req_addr, exp_fetch);
    check_eq("count", count, eq_pc.size());
    check_eq("instr_valid", instr_valid, eq_pc.size() != 0);
    if (instr_valid && eq_pc.size() != 0) begin
      check_eq("instr_pc", instr_pc, eq_pc[0]);
      check_eq("instr_data", instr_data, mem_word(eq_pc[0]));
    end
    check_eq("misalign_err", misalign_err, exp_mis);
    rf = imem_req_valid && imem_req_ready;
    pf = instr_valid && instr_ready;
    s_req_valid = imem_req_valid; s_req_fire = rf; s_req_addr = imem_req_addr;
    s_rsp_fire = imem_rsp_valid; s_ivalid = instr_valid; s_ipc = instr_pc;
    if (pf && !redirect_valid && eq_pc.size() != 0) void'(eq_pc.pop_front());
    if (imem_rsp_valid) begin
      if (!mq[0].stale && !redirect_valid) eq_pc.push_back(mq[0].addr);
      void'(mq.pop_front());
    end
    if (redirect_valid) begin
      foreach (mq[i]) mq[i].stale = 1'b1;
      eq_pc.delete();
`ifdef FETCH_MISALIGN_CHK_EN
      exp_mis = |redirect_pc[1:0];
      exp_fetch = redirect_pc;
`else
      exp_fetch = {redirect_pc[31:2], 2'b00};
`endif
    end else if (rf) exp_fetch += 4;
    if (rf) begin
      mq.push_back('{imem_req_addr, cyc + (mem_lat != 0 ? mem_lat : int'($urandom_range(1, 4))), redirect_valid});
      n_req++;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask
  task automatic do_reset();
    rst = 1'b1; en = 1'b1; redirect_valid = 1'b0; imem_rsp_valid = 1'b0;
    #1;
    check_eq("rst_req_valid", imem_req_valid, 0);
    check_eq("rst_instr_valid", instr_valid, 0);
    check_eq("rst_count", count, 0);
    check_eq("rst_misalign", misalign_err, 0);
    mq.delete(); eq_pc.delete(); exp_fetch = RPC; exp_mis = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic redirect_to(logic [31:0] pc);
    redirect_valid = 1'b1; redirect_pc = pc;
    tick();
    redirect_valid = 1'b0;
  endtask
  task automatic wait_ivalid(string tag, logic [31:0] exp);
    int k = 0;
    do begin tick(); k++; end while (!s_ivalid && k < 40);
    check_eq({tag, "_seen"}, s_ivalid, 1);
    check_eq(tag, s_ipc, exp);
  endtask
  task automatic wait_req(string tag, logic [31:0] exp);
    int k = 0;
    do begin tick(); k++; end while (!s_req_fire && k < 40);
    check_eq({tag, "_seen"}, s_req_fire, 1);
    check_eq(tag, s_req_addr, exp);
  endtask
  initial begin
    int n0;
    rst = 1'b1; en = 1'b0; imem_req_ready = 1'b1; instr_ready = 1'b1;
    redirect_valid = 1'b0; redirect_pc = '0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    @(negedge clk);
    do_reset();
    tick(); check_eq("seq0", s_req_addr, 32'h0040_0000); check_eq("seq0_fire", s_req_fire, 1);
    tick(); check_eq("seq1", s_req_addr, 32'h0040_0004); check_eq("seq1_ivalid", s_ivalid, 0);
    tick(); check_eq("seq2", s_req_addr, 32'h0040_0008); check_eq("seq2_ivalid", s_ivalid, 1);
    check_eq("seq2_ipc", s_ipc, 32'h0040_0000);
    do_reset(); instr_ready = 1'b0; n0 = n_req;
    repeat (8) tick();
    check_eq("full_reqs", n_req - n0, 4);
    check_eq("full_count", count, 4);
    check_eq("full_req_valid", s_req_valid, 0);
    instr_ready = 1'b1; tick(); instr_ready = 1'b0;
    tick(); check_eq("refill_fire", s_req_fire, 1); check_eq("refill_addr", s_req_addr, 32'h0040_0010);
    do_reset(); instr_ready = 1'b1; mem_lat = 3;
    tick(); tick(); en = 1'b0;
    redirect_to(32'h0040_0100); en = 1'b1;
    wait_ivalid("flush_ipc", 32'h0040_0100);
    do_reset(); mem_lat = 1;
    repeat (3) tick();
    redirect_to(32'h0040_0300);
    check_eq("redir_req_fire", s_req_fire, 1); check_eq("redir_rsp_fire", s_rsp_fire, 1);
    wait_ivalid("redir_ipc", 32'h0040_0300);
    do_reset(); mem_lat = 3; instr_ready = 1'b0;
    tick(); tick(); en = 1'b0; n0 = n_req;
    repeat (5) tick();
    check_eq("en_off_reqs", n_req - n0, 0);
    check_eq("en_off_count", count, 2);
    en = 1'b1; tick();
    check_eq("en_on_addr", s_req_addr, 32'h0040_0008); check_eq("en_on_fire", s_req_fire, 1);
    do_reset(); mem_lat = 1; instr_ready = 1'b1;
    tick(); tick();
    redirect_to(32'h0040_0102);
`ifdef FETCH_MISALIGN_CHK_EN
    tick(); tick();
    check_eq("mis_set", misalign_err, 1); check_eq("mis_block", s_req_valid, 0);
    redirect_to(32'h0040_0200);
    check_eq("mis_clear", misalign_err, 0);
    wait_req("mis_resume", 32'h0040_0200);
`else
    check_eq("mis_tied", misalign_err, 0);
    wait_req("mis_forced", 32'h0040_0100);
`endif
    mem_lat = 0; rsp_pct = 80;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      en = $urandom_range(9) != 0;
      imem_req_ready = $urandom_range(9) < 7;
      instr_ready = $urandom_range(9) < 6;
      redirect_valid = $urandom_range(31) == 0;
      redirect_pc = {16'h0040, 16'($urandom)};
`ifdef FETCH_MISALIGN_CHK_EN
      if ($urandom_range(3) != 0) redirect_pc[1:0] = 2'b00;
`endif
      tick();
    end
    redirect_valid = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
